// File: rtl/branch_pkg.sv
// -----------------------------------------------------------------------------
// branch_pkg
// Shared constants and types for the ID-stage branch resolution controller.
//   OP_BEQ / OP_BNE : opcodes of the two conditional branches understood here
//   state_e         : controller FSM state encoding
// -----------------------------------------------------------------------------
package branch_pkg;

    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        STALL    = 2'd1,
        REDIRECT = 2'd2
    } state_e;

endpackage

// File: rtl/branch_taken_eval.sv
// -----------------------------------------------------------------------------
// branch_taken_eval
// Combinational opcode decode and branch-condition evaluation.
//   Opcode   in  6  ID-stage opcode
//   Zero     in  1  operands equal
//   IsBranch out 1  opcode is BEQ or BNE
//   Taken    out 1  branch condition holds (always 0 for non-branches)
// -----------------------------------------------------------------------------
module branch_taken_eval
    import branch_pkg::*;
(
    input  logic [5:0] Opcode,
    input  logic       Zero,
    output logic       IsBranch,
    output logic       Taken
);

    always_comb begin
        IsBranch = 1'b0;
        Taken    = 1'b0;
        case (Opcode)
            OP_BEQ: begin
                IsBranch = 1'b1;
                Taken    = Zero;
            end
            OP_BNE: begin
                IsBranch = 1'b1;
                Taken    = !Zero;
            end
            default: begin
                IsBranch = 1'b0;
                Taken    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// -----------------------------------------------------------------------------
// branch_resolve_ctrl
// Resolves BEQ/BNE in the ID stage. Stalls IF/ID while a source operand is not
// yet forwardable, then issues a one-cycle registered redirect + flush for a
// taken branch. A sticky error flags stalls that outlast STALL_MAX cycles.
//
// Ports:
//   Clock          in   1       rising-edge clock
//   Reset_n        in   1       asynchronous active-low reset
//   IdValid        in   1       valid instruction in ID
//   Opcode         in   6       ID opcode
//   Zero           in   1       ID operands equal
//   OperandHazard  in   1       branch operand not yet forwardable
//   BranchTarget   in   ADDR_W  computed branch target
//   StallIfId      out  1       hold PC and IF/ID (combinational)
//   RedirectValid  out  1       load RedirectPc into PC (registered)
//   RedirectPc     out  ADDR_W  redirect address (registered, held when idle)
//   FlushIfId      out  1       squash IF/ID (registered, equals RedirectValid)
//   HazardErr      out  1       sticky: stall exceeded STALL_MAX
//   BranchCount    out  16      [BRANCH_STATS_EN] resolved branches, saturating
//   TakenCount     out  16      [BRANCH_STATS_EN] taken branches, saturating
//
// Optional feature macro: BRANCH_STATS_EN adds the two statistics counters.
// STALL_MAX must be at least 1.
// -----------------------------------------------------------------------------
module branch_resolve_ctrl
    import branch_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned STALL_MAX = 3
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              IdValid,
    input  logic [5:0]        Opcode,
    input  logic              Zero,
    input  logic              OperandHazard,
    input  logic [ADDR_W-1:0] BranchTarget,
    output logic              StallIfId,
    output logic              RedirectValid,
    output logic [ADDR_W-1:0] RedirectPc,
    output logic              FlushIfId,
    output logic              HazardErr
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0]       BranchCount,
    output logic [15:0]       TakenCount
`endif
);

    localparam int unsigned       CNT_W   = $clog2(STALL_MAX + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STALL_MAX);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    state_e              state_q, state_d;
    logic                is_branch;
    logic                taken;
    logic                branch_req;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic                hazard_err_q, hazard_err_d;
    logic                redirect_valid_q;
    logic [ADDR_W-1:0]   redirect_pc_q;

    branch_taken_eval u_taken_eval (
        .Opcode   (Opcode),
        .Zero     (Zero),
        .IsBranch (is_branch),
        .Taken    (taken)
    );

    assign branch_req = IdValid & is_branch;

    // In STALL the opcode is still valid because IF/ID is held, so the
    // decision ignores IdValid there.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (branch_req) begin
                    if (OperandHazard) begin
                        state_d = STALL;
                    end else if (taken) begin
                        state_d = REDIRECT;
                    end
                end
            end
            STALL: begin
                if (!OperandHazard) begin
                    state_d = taken ? REDIRECT : IDLE;
                end
            end
            REDIRECT: begin
                // ID holds a wrong-path instruction; it is ignored.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign StallIfId = ((state_q == IDLE) & branch_req & OperandHazard) |
                       ((state_q == STALL) & OperandHazard);

    // stall_cnt holds the number of STALL cycles including the current one,
    // so the error fires when the STALL_MAX-th stall cycle still sees a hazard.
    always_comb begin
        stall_cnt_d = '0;
        if (state_d == STALL) begin
            if (state_q != STALL) begin
                stall_cnt_d = CNT_ONE;
            end else if (stall_cnt_q < CNT_MAX) begin
                stall_cnt_d = stall_cnt_q + CNT_ONE;
            end else begin
                stall_cnt_d = stall_cnt_q;
            end
        end
    end

    assign hazard_err_d = hazard_err_q |
                          ((state_q == STALL) & OperandHazard & (stall_cnt_q == CNT_MAX));

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q          <= IDLE;
            stall_cnt_q      <= '0;
            hazard_err_q     <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            state_q          <= state_d;
            stall_cnt_q      <= stall_cnt_d;
            hazard_err_q     <= hazard_err_d;
            redirect_valid_q <= (state_d == REDIRECT);
            if (state_d == REDIRECT) begin
                redirect_pc_q <= BranchTarget;
            end
        end
    end

    assign RedirectValid = redirect_valid_q;
    assign FlushIfId     = redirect_valid_q;
    assign RedirectPc    = redirect_pc_q;
    assign HazardErr     = hazard_err_q;

`ifdef BRANCH_STATS_EN
    logic        resolve;
    logic        take;
    logic [15:0] branch_cnt_q;
    logic [15:0] taken_cnt_q;

    // A decision is made when the branch leaves IDLE/STALL without a hazard.
    assign resolve = ((state_q == IDLE) & branch_req & !OperandHazard) |
                     ((state_q == STALL) & !OperandHazard);
    assign take    = (state_d == REDIRECT) & (state_q != REDIRECT);

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            branch_cnt_q <= '0;
            taken_cnt_q  <= '0;
        end else begin
            if (resolve && (branch_cnt_q != 16'hFFFF)) begin
                branch_cnt_q <= branch_cnt_q + 16'd1;
            end
            if (take && (taken_cnt_q != 16'hFFFF)) begin
                taken_cnt_q <= taken_cnt_q + 16'd1;
            end
        end
    end

    assign BranchCount = branch_cnt_q;
    assign TakenCount  = taken_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_ctrl
// Directed stimulus with a redirect scoreboard: each expected redirect (target
// and cycle) is queued when the resolving inputs are driven; a monitor pops
// and compares on every cycle the DUT presents RedirectValid/FlushIfId.
// -----------------------------------------------------------------------------
module tb_branch_resolve_ctrl;

    localparam logic [5:0] BEQ = 6'b000100;
    localparam logic [5:0] BNE = 6'b000101;
    localparam logic [5:0] LW  = 6'b100011;

    logic        Clock;
    logic        Reset_n;
    logic        IdValid;
    logic [5:0]  Opcode;
    logic        Zero;
    logic        OperandHazard;
    logic [31:0] BranchTarget;
    logic        StallIfId;
    logic        RedirectValid;
    logic [31:0] RedirectPc;
    logic        FlushIfId;
    logic        HazardErr;
`ifdef BRANCH_STATS_EN
    logic [15:0] BranchCount;
    logic [15:0] TakenCount;
`endif

    typedef struct packed {
        logic [31:0] pc;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc;
    int   checks;
    int   errors;

    branch_resolve_ctrl #(
        .ADDR_W    (32),
        .STALL_MAX (3)
    ) dut (
        .Clock         (Clock),
        .Reset_n       (Reset_n),
        .IdValid       (IdValid),
        .Opcode        (Opcode),
        .Zero          (Zero),
        .OperandHazard (OperandHazard),
        .BranchTarget  (BranchTarget),
        .StallIfId     (StallIfId),
        .RedirectValid (RedirectValid),
        .RedirectPc    (RedirectPc),
        .FlushIfId     (FlushIfId),
        .HazardErr     (HazardErr)
`ifdef BRANCH_STATS_EN
        ,
        .BranchCount   (BranchCount),
        .TakenCount    (TakenCount)
`endif
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic z,
                         input logic hz, input logic [31:0] tgt);
        IdValid       = v;
        Opcode        = op;
        Zero          = z;
        OperandHazard = hz;
        BranchTarget  = tgt;
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Redirect resolved by inputs driven in the current cycle appears next cycle.
    task automatic expect_redirect(input logic [31:0] pc);
        exp_t e;
        e.pc  = pc;
        e.cyc = cyc + 1;
        exp_q.push_back(e);
    endtask

    // Monitor: any redirect/flush the DUT presents must match the queue head.
    always @(negedge Clock) begin
        exp_t e;
        if (Reset_n && (RedirectValid || FlushIfId)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_redirect: got pc %h valid %b flush %b, required none",
                         RedirectPc, RedirectValid, FlushIfId);
            end else begin
                e = exp_q.pop_front();
                chk("redirect_pc", RedirectPc, e.pc);
                chk("redirect_valid", {31'b0, RedirectValid}, 32'd1);
                chk("redirect_flush", {31'b0, FlushIfId}, 32'd1);
                chk("redirect_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, required finish within 100000 time units");
        $fatal(1, "timeout");
    end

    initial begin
        checks  = 0;
        errors  = 0;
        Reset_n = 1'b0;
        drive(1'b0, 6'd0, 1'b0, 1'b0, 32'd0);
        tick();
        tick();

        // Reset state
        chk("rst_redirect_valid", {31'b0, RedirectValid}, 32'd0);
        chk("rst_flush", {31'b0, FlushIfId}, 32'd0);
        chk("rst_redirect_pc", RedirectPc, 32'd0);
        chk("rst_hazard_err", {31'b0, HazardErr}, 32'd0);
        chk("rst_stall_idle", {31'b0, StallIfId}, 32'd0);
        // StallIfId still follows the IDLE equation during reset
        drive(1'b1, BEQ, 1'b1, 1'b1, 32'h40);
        #1;
        chk("rst_stall_follows", {31'b0, StallIfId}, 32'd1);
        drive(1'b0, 6'd0, 1'b0, 1'b0, 32'd0);
        Reset_n = 1'b1;
        tick();

        // BEQ taken, no hazard -> one-cycle redirect to 0x40
        drive(1'b1, BEQ, 1'b1, 1'b0, 32'h40);
        #1;
        chk("beq_no_stall", {31'b0, StallIfId}, 32'd0);
        expect_redirect(32'h40);
        tick();
        drive(1'b0, 6'd0, 1'b0, 1'b0, 32'd0);
        tick();
        chk("beq_valid_drops", {31'b0, RedirectValid}, 32'd0);
        chk("beq_flush_drops", {31'b0, FlushIfId}, 32'd0);

        // BNE not taken -> nothing
        drive(1'b1, BNE, 1'b1, 1'b0, 32'h80);
        #1;
        chk("bne_nt_stall", {31'b0, StallIfId}, 32'd0);
        tick();
        drive(1'b0, 6'd0, 1'b0, 1'b0, 32'd0);
        #1;
        chk("bne_nt_stall2", {31'b0, StallIfId}, 32'd0);
        tick();

        // Non-branch with hazard never stalls
        drive(1'b1, LW, 1'b1, 1'b1, 32'h500);
        #1;
        chk("lw_hazard_no_stall", {31'b0, StallIfId}, 32'd0);
        tick();

        // BEQ, hazard 2 cycles, then taken -> redirect to 0x100
        drive(1'b1, BEQ, 1'b0, 1'b1, 32'h100);
        #1;
        chk("beq_hz_stall1", {31'b0, StallIfId}, 32'd1);
        tick();
        chk("beq_hz_stall2", {31'b0, StallIfId}, 32'd1);
        tick();
        drive(1'b1, BEQ, 1'b1, 1'b0, 32'h100);
        #1;
        chk("beq_hz_released", {31'b0, StallIfId}, 32'd0);
        expect_redirect(32'h100);
        tick();
        drive(1'b0, 6'd0, 1'b0, 1'b0, 32'd0);
        chk("beq_hz_no_err", {31'b0, HazardErr}, 32'd0);
        tick();

        // BNE with hazard 5 cycles (IdValid dropped mid-stall), STALL_MAX=3
        drive(1'b1, BNE, 1'b1, 1'b1, 32'h200);
        tick();                                 // stall cycle 1
        chk("long_err_s1", {31'b0, HazardErr}, 32'd0);
        IdValid = 1'b0;
        tick();                                 // stall cycle 2
        chk("long_err_s2", {31'b0, HazardErr}, 32'd0);
        chk("long_stall_novalid", {31'b0, StallIfId}, 32'd1);
        tick();                                 // stall cycle 3
        chk("long_err_s3", {31'b0, HazardErr}, 32'd0);
        tick();                                 // stall cycle 4
        chk("long_err_s4", {31'b0, HazardErr}, 32'd1);
        chk("long_still_stall", {31'b0, StallIfId}, 32'd1);
        tick();                                 // stall cycle 5: hazard clears, BNE taken
        OperandHazard = 1'b0;
        Zero          = 1'b0;
        #1;
        chk("long_released", {31'b0, StallIfId}, 32'd0);
        expect_redirect(32'h200);
        tick();
        drive(1'b0, 6'd0, 1'b0, 1'b0, 32'd0);
        tick();
        tick();
        chk("err_sticky", {31'b0, HazardErr}, 32'd1);

        // Reset pulse during STALL drops the pending branch and clears the error
        drive(1'b1, BEQ, 1'b1, 1'b1, 32'h280);
        tick();
        OperandHazard = 1'b0;                   // would resolve taken without reset
        #1;
        Reset_n = 1'b0;
        #1;
        chk("rst_mid_err_clr", {31'b0, HazardErr}, 32'd0);
        chk("rst_mid_no_valid", {31'b0, RedirectValid}, 32'd0);
        tick();
        drive(1'b0, 6'd0, 1'b0, 1'b0, 32'd0);
        Reset_n = 1'b1;
        #1;
        chk("rst_mid_idle", {31'b0, StallIfId}, 32'd0);
        tick();
        tick();

        // Back-to-back BEQ during REDIRECT is ignored
        drive(1'b1, BEQ, 1'b1, 1'b0, 32'h300);
        expect_redirect(32'h300);
        tick();
        drive(1'b1, BEQ, 1'b1, 1'b1, 32'h400);
        #1;
        chk("redirect_ignores_stall", {31'b0, StallIfId}, 32'd0);
        OperandHazard = 1'b0;
        tick();
        drive(1'b0, 6'd0, 1'b0, 1'b0, 32'd0);
        tick();
        tick();
        chk("pc_held", RedirectPc, 32'h300);
        chk("pending_redirects", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_resolve_ctrl.md
BRANCH_RESOLVE_CTRL -- requirements
Module: branch_resolve_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, width of PC/target buses.
REQ-002 SHALL have parameter STALL_MAX, default 3, consecutive hazard-stall cycles tolerated before error flag.
REQ-003 SHALL have port Clock  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port Reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port IdValid  input  1  valid instruction in ID stage.
REQ-006 SHALL have port Opcode  input  6  ID-stage instruction opcode.
REQ-007 SHALL have port Zero  input  1  ID-stage operand equality (1 = operands equal).
REQ-008 SHALL have port OperandHazard  input  1  a branch source operand is not yet forwardable.
REQ-009 SHALL have port BranchTarget  input  ADDR_W  ID-stage computed branch target.
REQ-010 SHALL have port StallIfId  output  1  hold PC and IF/ID register (combinational).
REQ-011 SHALL have port RedirectValid  output  1  load RedirectPc into PC this cycle (registered).
REQ-012 SHALL have port RedirectPc  output  ADDR_W  redirect address (registered).
REQ-013 SHALL have port FlushIfId  output  1  squash IF/ID contents this cycle (registered, equals RedirectValid).
REQ-014 SHALL have port HazardErr  output  1  sticky: stall exceeded STALL_MAX.

Function
REQ-015 SHALL classify: BEQ = 6'b000100 taken when Zero=1; BNE = 6'b000101 taken when Zero=0; all other opcodes are non-branch and produce no action.
REQ-016 SHALL implement FSM states IDLE, STALL, REDIRECT.
REQ-017 IDLE: IdValid & branch & OperandHazard -> STALL; IdValid & branch & !OperandHazard & taken -> REDIRECT, capturing BranchTarget; otherwise stay IDLE.
REQ-018 STALL: while OperandHazard=1 stay STALL; on OperandHazard=0 evaluate taken in that cycle: taken -> REDIRECT (capture BranchTarget), not taken -> IDLE.
REQ-019 StallIfId SHALL = (IDLE & IdValid & branch & OperandHazard) | (STALL & OperandHazard); zero-cycle combinational path.
REQ-020 REDIRECT: RedirectValid=1 and FlushIfId=1 for exactly one cycle; Opcode/IdValid ignored (wrong-path instruction); unconditionally -> IDLE.
REQ-021 Latency: branch resolved at cycle N -> RedirectValid at cycle N+1; not-taken branch produces no redirect and no flush.
REQ-022 RedirectPc SHALL hold its last captured value while RedirectValid=0.
REQ-023 Stall counter SHALL count consecutive STALL cycles, saturate at STALL_MAX, clear on leaving STALL; HazardErr set when counter = STALL_MAX and OperandHazard still 1; stall continues regardless.
REQ-024 HazardErr SHALL remain set until reset.
REQ-025 IdValid=0 in STALL SHALL NOT abort the stall (ID held by StallIfId).

Reset
REQ-026 Reset_n=0 SHALL asynchronously force state IDLE, RedirectValid=0, FlushIfId=0, RedirectPc=0, stall counter=0, HazardErr=0; StallIfId then follows REQ-019 from IDLE.
REQ-027 Reset asserted in STALL or REDIRECT SHALL drop any pending redirect; no redirect after deassertion.

Configuration
REQ-028 With BRANCH_STATS_EN defined, SHALL add outputs BranchCount[15:0] (resolved branches, counted on leaving IDLE/STALL with a decision) and TakenCount[15:0] (entries into REDIRECT), both saturating at 16'hFFFF, reset to 0.
REQ-029 Without BRANCH_STATS_EN, those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-030 Package branch_pkg SHALL hold OP_BEQ, OP_BNE opcode constants and the FSM state enum.
REQ-031 Sub-module branch_taken_eval SHALL be the combinational opcode-decode/taken evaluator (Opcode, Zero -> IsBranch, Taken).

Verification
REQ-032 BEQ, Zero=1, no hazard, target 0x0000_0040 -> next cycle RedirectValid=1, FlushIfId=1, RedirectPc=0x40, then both 0.
REQ-033 BNE, Zero=1, no hazard -> no redirect, no flush, StallIfId=0 throughout.
REQ-034 BEQ with OperandHazard high 2 cycles, then low with Zero=1, target 0x100 -> StallIfId=1 for 2 cycles, RedirectValid next cycle, RedirectPc=0x100, HazardErr=0.
REQ-035 OperandHazard held 5 cycles with STALL_MAX=3 -> HazardErr=1 from 4th stall cycle, stays 1 after hazard clears until Reset_n.
REQ-036 Reset_n pulsed low during STALL -> state IDLE, no RedirectValid afterward; back-to-back BEQ in REDIRECT cycle is ignored.
